// File: rtl/waterfall_sched_if.sv
// Spectrum stream handshake into the waterfall scheduler.
interface waterfall_sched_if;
   logic       i_s_valid;
   logic [7:0] i_s_data;
   logic       i_s_last;
   logic       o_s_ready;

   modport master (output i_s_valid, i_s_data, i_s_last, input o_s_ready);
   modport slave  (input i_s_valid, i_s_data, i_s_last, output o_s_ready);
endinterface

// File: rtl/waterfall_sched.sv
// Waterfall scheduler: decimates incoming spectra, writes kept spectra as
// lines into a circular waterfall RAM, and generates the display read address
// walking from the newest line downwards.
module waterfall_sched #(
   parameter int unsigned LINE_LEN  = 512,
   parameter int unsigned NUM_LINES = 256
) (
   input  logic                                            clk,
   input  logic                                            rst,
   waterfall_sched_if.slave                                s,
   input  logic [3:0]                                      i_decim,
   output logic                                            o_wr_en,
   output logic [$clog2(LINE_LEN)+$clog2(NUM_LINES)-1:0]   o_wr_addr,
   output logic [7:0]                                      o_wr_data,
   input  logic                                            i_wf_sync,
   input  logic                                            i_line_adv,
   input  logic [9:0]                                      i_x,
   output logic [$clog2(LINE_LEN)+$clog2(NUM_LINES)-1:0]   o_rd_addr,
   output logic [$clog2(NUM_LINES)-1:0]                    o_head,
   output logic                                            o_err_short,
   output logic                                            o_err_long
);

   localparam int unsigned LB = $clog2(LINE_LEN);
   localparam int unsigned HB = $clog2(NUM_LINES);
   localparam int unsigned AW = LB + HB;

   typedef enum logic [1:0] {IDLE, WRITE, DROP, COMMIT} state_t;

   state_t         state_q, state_d;
   logic [LB:0]    bin_q, bin_d;      // saturates at LINE_LEN (top bit = overlong)
   logic [3:0]     dcnt_q, dcnt_d;
   logic [3:0]     dmax_q, dmax_d;
   logic [HB-1:0]  head_q, head_d;
   logic           ready_q;
   logic           wr_en_q, wr_en_d;
   logic [AW-1:0]  wr_addr_q, wr_addr_d;
   logic [7:0]     wr_data_q, wr_data_d;
   logic           err_s_q, err_s_d;
   logic           err_l_q, err_l_d;

   logic           sync_q;
   logic [HB-1:0]  rd_line_q;
   logic [AW-1:0]  rd_addr_q;

   logic           beat;
   logic [LB:0]    cur_bin;
   logic [LB:0]    bin_inc;
   logic [3:0]     dec_sample;
   logic [3:0]     eff_max;
   logic [4:0]     dcnt_inc;
   logic [3:0]     dcnt_adv;
   logic           keep_beat;
   logic [LB-1:0]  col;

   assign beat       = s.i_s_valid & ready_q;
   assign dec_sample = (i_decim == 4'd0) ? 4'd1 : i_decim;
   assign col        = LB'(i_x);

   // Write FSM next state, RAM write port and error pulses.
   always_comb begin
      state_d   = state_q;
      bin_d     = bin_q;
      dcnt_d    = dcnt_q;
      dmax_d    = dmax_q;
      head_d    = head_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      err_s_d   = 1'b0;
      err_l_d   = 1'b0;
      keep_beat = 1'b0;

      // The beat accepted in IDLE is bin 0 of a new spectrum.
      cur_bin  = (state_q == IDLE) ? '0 : bin_q;
      bin_inc  = cur_bin[LB] ? cur_bin : cur_bin + (LB+1)'(1);
      // The decimation ratio is sampled on the first beat, so a spectrum that
      // also ends on that beat must use the live input rather than dmax_q.
      eff_max  = (state_q == IDLE) ? dec_sample : dmax_q;
      dcnt_inc = {1'b0, dcnt_q} + 5'd1;
      dcnt_adv = (dcnt_inc >= {1'b0, eff_max}) ? '0 : dcnt_inc[3:0];

      case (state_q)
         IDLE, WRITE: begin
            if (beat) begin
               if (state_q == IDLE) dmax_d = dec_sample;
               keep_beat = (state_q == WRITE) || (dcnt_q == 4'd0);
               if (keep_beat) begin
                  if (!cur_bin[LB]) begin
                     wr_en_d   = 1'b1;
                     wr_addr_d = {head_q, cur_bin[LB-1:0]};
                     wr_data_d = s.i_s_data;
                  end
                  bin_d = bin_inc;
                  if (s.i_s_last) begin
                     dcnt_d = dcnt_adv;
                     if (cur_bin < (LB+1)'(LINE_LEN - 1)) begin
                        err_s_d = 1'b1;
                        state_d = IDLE;
                     end else begin
                        err_l_d = cur_bin[LB];
                        state_d = COMMIT;
                     end
                  end else begin
                     state_d = WRITE;
                  end
               end else if (s.i_s_last) begin
                  dcnt_d  = dcnt_adv;
                  state_d = IDLE;
               end else begin
                  state_d = DROP;
               end
            end
         end
         DROP: begin
            if (beat && s.i_s_last) begin
               dcnt_d  = dcnt_adv;
               state_d = IDLE;
            end
         end
         COMMIT: begin
            head_d  = head_q + HB'(1);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Write-side state registers; ready is registered so it stays low in reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         bin_q     <= '0;
         dcnt_q    <= '0;
         dmax_q    <= 4'd1;
         head_q    <= '0;
         ready_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         err_s_q   <= 1'b0;
         err_l_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         bin_q     <= bin_d;
         dcnt_q    <= dcnt_d;
         dmax_q    <= dmax_d;
         head_q    <= head_d;
         ready_q   <= (state_d != COMMIT);
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         err_s_q   <= err_s_d;
         err_l_q   <= err_l_d;
      end
   end

   // Reader: latch newest line on frame sync edge, step down per video line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q    <= 1'b0;
         rd_line_q <= '1;
         rd_addr_q <= '0;
      end else begin
         sync_q    <= i_wf_sync;
         if (i_wf_sync && !sync_q) begin
            rd_line_q <= head_q - HB'(1);
         end else if (i_line_adv) begin
            rd_line_q <= rd_line_q - HB'(1);
         end
         rd_addr_q <= {rd_line_q, col};
      end
   end

   assign s.o_s_ready  = ready_q;
   assign o_wr_en      = wr_en_q;
   assign o_wr_addr    = wr_addr_q;
   assign o_wr_data    = wr_data_q;
   assign o_rd_addr    = rd_addr_q;
   assign o_head       = head_q;
   assign o_err_short  = err_s_q;
   assign o_err_long   = err_l_q;

endmodule

// File: tb/tb_waterfall_sched.sv
// Bench for waterfall_sched: spectrum-level reference model plus directed and
// randomized spectra and reader activity.
module tb_waterfall_sched;
   localparam int L   = 512;
   localparam int N   = 256;
   localparam int AW  = 17;
   localparam int HBW = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   waterfall_sched_if sif();
   logic [3:0]    decim;
   logic          wf_sync, line_adv;
   logic [9:0]    x;
   logic          wr_en, err_s, err_l;
   logic [AW-1:0] wr_addr, rd_addr;
   logic [7:0]    wr_data;
   logic [HBW-1:0] head;

   waterfall_sched #(.LINE_LEN(L), .NUM_LINES(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .s           (sif),
      .i_decim     (decim),
      .o_wr_en     (wr_en),
      .o_wr_addr   (wr_addr),
      .o_wr_data   (wr_data),
      .i_wf_sync   (wf_sync),
      .i_line_adv  (line_adv),
      .i_x         (x),
      .o_rd_addr   (rd_addr),
      .o_head      (head),
      .o_err_short (err_s),
      .o_err_long  (err_l)
   );

   int total = 0;
   int bad   = 0;
   int n_wr = 0, n_es = 0, n_el = 0;
   bit gaps_en = 0;
   bit rnd_done = 0;

   // Reference model state (spectrum-level).
   bit m_ready = 0, m_commit = 0, m_in = 0, m_keep = 0, m_sync_prev = 0;
   int m_head = 0, m_dcnt = 0, m_dmax = 1, m_bin = 0, m_rd_line = N - 1;
   bit exp_en = 0, exp_es = 0, exp_el = 0;
   int exp_addr = 0, exp_data = 0, exp_rd_addr = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ready = 0; m_commit = 0; m_in = 0; m_keep = 0; m_sync_prev = 0;
         m_head = 0; m_dcnt = 0; m_dmax = 1; m_bin = 0; m_rd_line = N - 1;
         exp_en = 0; exp_es = 0; exp_el = 0;
         exp_addr = 0; exp_data = 0; exp_rd_addr = 0;
      end else begin
         bit beat;
         beat = sif.i_s_valid && m_ready;
         exp_en = 0; exp_es = 0; exp_el = 0;
         exp_rd_addr = m_rd_line * L + (int'(x) % L);
         if (wf_sync && !m_sync_prev) m_rd_line = (m_head + N - 1) % N;
         else if (line_adv)           m_rd_line = (m_rd_line + N - 1) % N;
         m_sync_prev = wf_sync;
         if (m_commit) begin
            m_head   = (m_head + 1) % N;
            m_commit = 0;
         end else if (beat) begin
            if (!m_in) begin
               m_in   = 1;
               m_bin  = 0;
               m_dmax = (decim == 0) ? 1 : int'(decim);
               m_keep = (m_dcnt == 0);
            end
            if (m_keep && m_bin < L) begin
               exp_en   = 1;
               exp_addr = m_head * L + m_bin;
               exp_data = int'(sif.i_s_data);
            end
            if (sif.i_s_last) begin
               m_dcnt = (m_dcnt + 1) % m_dmax;
               m_in   = 0;
               if (m_keep) begin
                  if (m_bin < L - 1) exp_es = 1;
                  else begin
                     exp_el   = (m_bin >= L);
                     m_commit = 1;
                  end
               end
            end
            m_bin++;
         end
         m_ready = !m_commit;
      end
   end

   always @(negedge clk) begin
      chk("ready", sif.o_s_ready, m_ready);
      chk("wr_en", wr_en, exp_en);
      if (exp_en || rst) begin
         chk("wr_addr", wr_addr, exp_addr);
         chk("wr_data", wr_data, exp_data);
      end
      chk("head", head, m_head);
      chk("err_short", err_s, exp_es);
      chk("err_long", err_l, exp_el);
      chk("rd_addr", rd_addr, exp_rd_addr);
      if (wr_en === 1'b1) n_wr++;
      if (err_s === 1'b1) n_es++;
      if (err_l === 1'b1) n_el++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [7:0] d, input bit last);
      int w;
      bit r;
      if (gaps_en && $urandom_range(0, 7) == 0) begin
         sif.i_s_valid = 1'b0;
         tick(1);
      end
      sif.i_s_valid = 1'b1;
      sif.i_s_data  = d;
      sif.i_s_last  = last;
      w = 0;
      do begin
         @(negedge clk);
         r = sif.o_s_ready;
         @(posedge clk);
         #1;
         w++;
      end while (!r && w < 20);
      if (!r) begin
         total++;
         bad++;
         $display("FAIL handshake_timeout: ready stayed %0d for %0d cycles", r, w);
      end
   endtask

   task automatic spectrum(input int len);
      for (int i = 0; i < len; i++) send_beat(8'($urandom), i == len - 1);
      sif.i_s_valid = 1'b0;
      sif.i_s_last  = 1'b0;
   endtask

   task automatic do_reset();
      sif.i_s_valid = 1'b0;
      sif.i_s_last  = 1'b0;
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
   endtask

   initial begin
      int w0, e0;
      rst = 1'b1;
      sif.i_s_valid = 1'b0; sif.i_s_data = '0; sif.i_s_last = 1'b0;
      decim = 4'd1; wf_sync = 1'b0; line_adv = 1'b0; x = '0;
      tick(3);
      chk("ready_in_reset", sif.o_s_ready, 0);
      rst = 1'b0;
      tick(1);
      chk("ready_after_release", sif.o_s_ready, 1);

      // Two full spectra at decim 1.
      w0 = n_wr;
      spectrum(512);
      spectrum(512);
      tick(3);
      chk("two_spectra_head", head, 2);
      chk("two_spectra_writes", n_wr - w0, 1024);

      // Decimation by 3 over six spectra.
      do_reset();
      decim = 4'd3;
      w0 = n_wr;
      repeat (6) spectrum(512);
      tick(3);
      chk("decim3_head", head, 2);
      chk("decim3_writes", n_wr - w0, 1024);
      decim = 4'd1;

      // Short spectrum abandons the line; next one reuses it.
      e0 = n_es;
      spectrum(300);
      tick(3);
      chk("short_head", head, 2);
      chk("short_err_pulses", n_es - e0, 1);
      spectrum(512);
      tick(3);
      chk("after_short_head", head, 3);

      // Overlong spectrum is truncated but committed.
      w0 = n_wr;
      e0 = n_el;
      spectrum(600);
      tick(3);
      chk("long_writes", n_wr - w0, 512);
      chk("long_err_pulses", n_el - e0, 1);
      chk("long_head", head, 4);

      // Reader walk from head 0.
      do_reset();
      x = 10'd5;
      wf_sync = 1'b1;
      tick(2);
      chk("rd_line255", rd_addr, 255 * L + 5);
      for (int k = 1; k <= 3; k++) begin
         line_adv = 1'b1;
         tick(1);
         line_adv = 1'b0;
         tick(1);
         chk("rd_line_step", rd_addr, (255 - k) * L + 5);
      end
      wf_sync = 1'b0;
      tick(2);

      // Reset in the middle of a line.
      for (int i = 0; i < 200; i++) send_beat(8'($urandom), 1'b0);
      sif.i_s_valid = 1'b0;
      rst = 1'b1;
      tick(1);
      chk("midreset_wr_en", wr_en, 0);
      chk("midreset_head", head, 0);
      tick(2);
      rst = 1'b0;
      spectrum(512);
      tick(3);
      chk("midreset_after_head", head, 1);

      // Randomized spectra with concurrent reader activity.
      gaps_en = 1;
      fork
         begin
            for (int s = 0; s < 25; s++) begin
               int len;
               decim = 4'($urandom_range(0, 4));
               case ($urandom_range(0, 3))
                  0:       len = 512;
                  1:       len = $urandom_range(510, 514);
                  2:       len = $urandom_range(1, 8);
                  default: len = $urandom_range(200, 700);
               endcase
               spectrum(len);
               tick($urandom_range(0, 3));
            end
            rnd_done = 1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #2;
               if ($urandom_range(0, 15) == 0) wf_sync = ~wf_sync;
               line_adv = ($urandom_range(0, 3) == 0);
               x = 10'($urandom);
            end
            line_adv = 1'b0;
         end
      join
      tick(5);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/waterfall_sched.md
WATERFALL_SCHED -- requirements
Module: waterfall_sched

Interface
REQ-001 SHALL have parameter LINE_LEN, default 512, meaning bins per spectrum and pixels per waterfall line (power of two).
REQ-002 SHALL have parameter NUM_LINES, default 256, meaning waterfall RAM depth in lines (power of two).
REQ-003 SHALL have port clk  input  1  pixel/system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports i_s_valid / i_s_data / i_s_last  input  1/8/1  spectrum stream: valid, dB bin value, last bin of spectrum.
REQ-006 SHALL have port o_s_ready  output  1  stream ready; a beat transfers when i_s_valid & o_s_ready.
REQ-007 SHALL have port i_decim  input  4  keep one spectrum in i_decim; 0 treated as 1.
REQ-008 SHALL have ports o_wr_en / o_wr_addr / o_wr_data  output  1/log2(LINE_LEN*NUM_LINES)/8  waterfall RAM write port; address = {line, bin}.
REQ-009 SHALL have port i_wf_sync  input  1  screen flag, high on the last spectrum line before the waterfall region.
REQ-010 SHALL have port i_line_adv  input  1  one-cycle pulse per video line inside the waterfall region.
REQ-011 SHALL have port i_x  input  10  current active pixel column from screen.
REQ-012 SHALL have port o_rd_addr  output  log2(LINE_LEN*NUM_LINES)  waterfall RAM read address = {rd_line, i_x[log2(LINE_LEN)-1:0]}.
REQ-013 SHALL have ports o_head / o_err_short / o_err_long  output  log2(NUM_LINES)/1/1  committed head pointer; one-cycle error pulses.

Function
REQ-014 SHALL implement write FSM with states IDLE, WRITE, DROP, COMMIT.
REQ-015 IDLE: o_s_ready=1; on first accepted beat, latch keep = (decim_cnt==0); go WRITE if keep, else DROP; this beat is bin 0.
REQ-016 decim_cnt SHALL count 0..max(i_decim,1)-1, with i_decim sampled at spectrum start, advancing once per completed spectrum, wrapping to 0; first spectrum after reset is kept.
REQ-017 WRITE: each accepted beat SHALL produce o_wr_en=1, o_wr_addr={head, bin}, o_wr_data=i_s_data, registered one cycle after the beat; bin increments per beat.
REQ-018 Beats with bin >= LINE_LEN SHALL NOT be written; o_err_long SHALL pulse once at the last beat of such a spectrum, and the line is still committed.
REQ-019 i_s_last with bin < LINE_LEN-1 SHALL abandon the line: head unchanged, o_err_short pulses one cycle, FSM returns to IDLE.
REQ-020 A complete line (last at bin >= LINE_LEN-1) SHALL enter COMMIT for exactly one cycle: o_s_ready=0, head <= head+1 modulo NUM_LINES, then IDLE.
REQ-021 DROP: o_s_ready=1, no writes, until i_s_last is accepted, then IDLE; decim_cnt advances.
REQ-022 o_s_ready SHALL be 1 in IDLE, WRITE and DROP; 0 only in COMMIT and in reset.
REQ-023 Reader: on rising edge of i_wf_sync, rd_line <= head-1 modulo NUM_LINES (newest line at top).
REQ-024 Each i_line_adv pulse SHALL decrement rd_line modulo NUM_LINES; 0 wraps to NUM_LINES-1.
REQ-025 o_rd_addr SHALL be registered, one cycle latency from i_x / rd_line.
REQ-026 A commit in the same cycle as the i_wf_sync rising edge: reader latches the pre-commit head (line appears next frame).
REQ-027 i_line_adv coincident with the i_wf_sync rising edge: the latch wins; no decrement.
REQ-028 o_head SHALL equal the committed head (next line to be written).

Reset
REQ-029 On rst: FSM=IDLE, head=0, bin=0, decim_cnt=0, rd_line=NUM_LINES-1, o_s_ready=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_rd_addr=0, o_err_short=0, o_err_long=0.
REQ-030 Reset mid-line SHALL discard the partial line; the first spectrum after release is kept and written to line 0.
REQ-031 o_s_ready SHALL rise the first clock after rst deasserts.

Verification
REQ-032 Two 512-beat spectra, i_decim=1 -> writes at addr 0..511 then 512..1023; o_head 0->1->2; one ready-low cycle after each last.
REQ-033 i_decim=3, six spectra -> only spectra 1 and 4 written (lines 0,1); o_head=2.
REQ-034 Spectrum with last at beat 300 -> no commit, o_err_short pulse, o_head unchanged; next full spectrum written to the same line.
REQ-035 600-beat spectrum -> 512 writes, o_err_long pulse at beat 600, o_head+1.
REQ-036 head=0, i_wf_sync rising, then 3 i_line_adv pulses, i_x=5 -> o_rd_addr lines 255,254,253,252 with column 5.
REQ-037 rst asserted at beat 200 of a line -> outputs at reset values; after release, spectrum written at line 0, o_head=1.
